// File: rtl/sm_mul_arbiter.sv
// rtl/sm_mul_arbiter.sv - round-robin sequencer sharing one sequential multiplier between two requesters
// Outputs are decoded from registered state and operand latches only; nothing combinational from inputs.
module sm_mul_arbiter #(
   parameter int W       = 8,
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [W-1:0] x0,
   input  logic [W-1:0] y0,
   output logic         ack0,
   input  logic         req1,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] y1,
   output logic         ack1,
   output logic [W-1:0] res,
   output logic         err,
   output logic         busy,
   output logic         gnt,
   output logic         mul_bgn,
   output logic [W-1:0] mul_ibus,
   input  logic         mul_fin,
   input  logic [W-1:0] mul_obus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_X = 3'd1;
   localparam logic [2:0] S_LOAD_Y = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [2:0]    state;
   logic [W-1:0]  opx;
   logic [W-1:0]  opy;
   logic [W-1:0]  res_q;
   logic          err_q;
   logic          gnt_q;
   logic          last;
   logic [CW-1:0] cnt;

   logic any_req;
   logic winner;

   // On a tie the requester not served last wins; otherwise whoever asks.
   assign any_req = req0 | req1;
   assign winner  = (req0 & req1) ? ~last : req1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         opx   <= '0;
         opy   <= '0;
         res_q <= '0;
         err_q <= 1'b0;
         gnt_q <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  gnt_q <= winner;
                  last  <= winner;
                  opx   <= winner ? x1 : x0;
                  opy   <= winner ? y1 : y0;
                  state <= S_LOAD_X;
               end
            end
            S_LOAD_X: begin
               state <= S_LOAD_Y;
            end
            S_LOAD_Y: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // fin is honoured only here, so a stale fin cannot finish a fresh job
               if (mul_fin) begin
                  res_q <= mul_obus;
                  err_q <= 1'b0;
                  state <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  res_q <= '0;
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state != S_IDLE);
   assign mul_bgn  = (state == S_LOAD_X) || (state == S_LOAD_Y);
   assign mul_ibus = (state == S_LOAD_X) ? opx :
                     (state == S_LOAD_Y) ? opy : '0;
   assign ack0     = (state == S_DONE) && !gnt_q;
   assign ack1     = (state == S_DONE) &&  gnt_q;
   assign res      = res_q;
   assign err      = err_q;
   assign gnt      = gnt_q;

endmodule

// File: tb/tb_sm_mul_arbiter.sv
// tb/tb_sm_mul_arbiter.sv - directed bench for sm_mul_arbiter with a behavioural multiplier mock
// The mock returns the low byte of x*y a programmable number of cycles after bgn falls.
module tb_sm_mul_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] x0, y0, x1, y1;
   logic       ack0, ack1;
   logic [7:0] res;
   logic       err, busy, gnt;
   logic       mul_bgn;
   logic [7:0] mul_ibus;
   logic       mul_fin;
   logic [7:0] mul_obus;

   int total = 0;
   int bad   = 0;

   logic        bgn_q, armed, mock_en, stale_fin, fin_pulse;
   logic [7:0]  mx, my, mock_obus, stale_val;
   logic [15:0] prod;
   int          cd, mock_delay;

   sm_mul_arbiter #(.W(8), .TIMEOUT(16), .CW(5)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .x0(x0), .y0(y0), .ack0(ack0),
      .req1(req1), .x1(x1), .y1(y1), .ack1(ack1),
      .res(res), .err(err), .busy(busy), .gnt(gnt),
      .mul_bgn(mul_bgn), .mul_ibus(mul_ibus),
      .mul_fin(mul_fin), .mul_obus(mul_obus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic mock_update();
      if (mul_bgn && !bgn_q) mx = mul_ibus;
      else if (mul_bgn && bgn_q) my = mul_ibus;
      fin_pulse = 1'b0;
      if (!mul_bgn && bgn_q) begin
         cd    = mock_delay;
         armed = mock_en;
      end
      if (armed) begin
         if (cd == 0) begin
            fin_pulse = 1'b1;
            prod      = mx * my;
            mock_obus = prod[7:0];
            armed     = 1'b0;
         end else begin
            cd = cd - 1;
         end
      end
      bgn_q    = mul_bgn;
      mul_fin  = stale_fin | fin_pulse;
      mul_obus = stale_fin ? stale_val : mock_obus;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      mock_update();
   endtask

   // Called at an IDLE negedge with requests set; returns at the IDLE negedge after the ack.
   task automatic run_job(input logic g, input logic [7:0] ex, input logic [7:0] ey,
                          input logic [7:0] eres, input logic eerr, input int elat, input bit mutate);
      int   n;
      int   waitc;
      logic got;
      step();
      chk("ldx_bgn", mul_bgn, 1);
      chk("ldx_ibus", mul_ibus, ex);
      chk("gnt", gnt, g);
      if (mutate) begin
         x0 = 8'hFF;
         y0 = 8'h00;
      end
      step();
      chk("ldy_bgn", mul_bgn, 1);
      chk("ldy_ibus", mul_ibus, ey);
      n = 2; waitc = 0; got = 1'b0;
      while (!got && n < 40) begin
         step();
         n++;
         if (ack0 | ack1) got = 1'b1;
         else if (busy && !mul_bgn && mul_ibus == 8'h00) waitc++;
      end
      chk("ack_seen", got, 1);
      chk("latency", n, elat);
      chk("wait_cycles", waitc, elat - 3);
      chk("ack0", ack0, !g);
      chk("ack1", ack1, g);
      chk("res", res, eres);
      chk("err", err, eerr);
      step();
      chk("ack_low", ack0 | ack1, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      x0 = 8'h00; y0 = 8'h00; x1 = 8'h00; y1 = 8'h00;
      bgn_q = 1'b0; armed = 1'b0; mock_en = 1'b1; stale_fin = 1'b0; fin_pulse = 1'b0;
      mx = 8'h00; my = 8'h00; mock_obus = 8'h00; stale_val = 8'h00; prod = 16'h0;
      cd = 0; mock_delay = 0;
      mul_fin = 1'b0; mul_obus = 8'h00;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ack", {ack0, ack1}, 0);
      chk("rst_res", res, 8'h00);
      chk("rst_err", err, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_bgn", mul_bgn, 0);
      chk("rst_ibus", mul_ibus, 8'h00);

      // both requesters held from reset: 0,1,0,1
      req0 = 1'b1; req1 = 1'b1;
      x0 = 8'h03; y0 = 8'h05; x1 = 8'h07; y1 = 8'h02;
      rst = 1'b0;
      run_job(1'b0, 8'h03, 8'h05, 8'h0F, 1'b0, 4, 1'b0);
      run_job(1'b1, 8'h07, 8'h02, 8'h0E, 1'b0, 4, 1'b0);
      run_job(1'b0, 8'h03, 8'h05, 8'h0F, 1'b0, 4, 1'b0);
      run_job(1'b1, 8'h07, 8'h02, 8'h0E, 1'b0, 4, 1'b0);
      req0 = 1'b0; req1 = 1'b0;

      // single request, fin 10 cycles after bgn falls, operands changed after grant
      mock_delay = 10;
      req0 = 1'b1; x0 = 8'h97; y0 = 8'h83;
      run_job(1'b0, 8'h97, 8'h83, 8'h45, 1'b0, 14, 1'b1);
      req0 = 1'b0;
      step();
      chk("t1_busy", busy, 0);
      chk("t1_ack", ack0, 0);
      chk("t1_res_hold", res, 8'h45);
      chk("t1_gnt_hold", gnt, 0);

      // watchdog then a normal job
      mock_en = 1'b0;
      req1 = 1'b1; x1 = 8'h11; y1 = 8'h22;
      run_job(1'b1, 8'h11, 8'h22, 8'h00, 1'b1, 19, 1'b0);
      mock_en = 1'b1; mock_delay = 2;
      run_job(1'b1, 8'h11, 8'h22, 8'h42, 1'b0, 6, 1'b0);
      req1 = 1'b0;

      // stale fin held high before and during the request
      mock_en = 1'b0; stale_fin = 1'b1; stale_val = 8'h5A;
      mock_update();
      step();
      chk("stale_idle", busy, 0);
      req0 = 1'b1; x0 = 8'h01; y0 = 8'h02;
      run_job(1'b0, 8'h01, 8'h02, 8'h5A, 1'b0, 4, 1'b0);
      req0 = 1'b0; stale_fin = 1'b0;
      mock_update();
      mock_en = 1'b1;

      // reset during WAIT: last was 0, reset restores requester 0 priority
      mock_en = 1'b0;
      req0 = 1'b1; x0 = 8'h03; y0 = 8'h05;
      step(); step(); step(); step();
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_bgn", mul_bgn, 0);
      chk("arst_res", res, 8'h00);
      chk("arst_ack", {ack0, ack1}, 0);
      step();
      chk("rst_hold_ack", {ack0, ack1}, 0);
      rst = 1'b0;
      req1 = 1'b1; x1 = 8'h07; y1 = 8'h02;
      mock_en = 1'b1; mock_delay = 0;
      run_job(1'b0, 8'h03, 8'h05, 8'h0F, 1'b0, 4, 1'b0);
      run_job(1'b1, 8'h07, 8'h02, 8'h0E, 1'b0, 4, 1'b0);
      req1 = 1'b0;

      // reset during LOAD_X drops bgn without a clock
      mock_en = 1'b0;
      step();
      chk("ldx_pre", mul_bgn, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_ldx_bgn", mul_bgn, 0);
      chk("arst_ldx_ibus", mul_ibus, 8'h00);
      req0 = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sm_mul_arbiter.md
Name: sm_mul_arbiter

Overview:
- Sequencer and arbiter that shares one sequential 8-bit multiplier unit between two requesters.
- Latches a requester's operand pair and drives the multiplier's begin/operand-bus protocol: bgn held high for two cycles, X on the first, Y on the second.
- Waits for the multiplier's fin, captures its result and returns it with a one-cycle acknowledge.
- Arbitration is round-robin; a watchdog aborts a multiplication that never finishes.

Parameters:
- W, 8, operand/result width (matches multiplier ibus/obus).
- TIMEOUT, 16, max cycles spent in WAIT before abort (>=2).
- CW, 5, watchdog counter width; must hold TIMEOUT-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high. Clears all state.
- req0  in  1  requester 0 request; held high with stable x0/y0 until ack0.
- x0  in  W  requester 0 first operand.
- y0  in  W  requester 0 second operand.
- ack0  out  1  one-cycle pulse: res/err valid for requester 0.
- req1  in  1  requester 1 request.
- x1  in  W  requester 1 first operand.
- y1  in  W  requester 1 second operand.
- ack1  out  1  one-cycle pulse: res/err valid for requester 1.
- res  out  W  result register; valid in the ack cycle, then held.
- err  out  1  high with ack when the transaction timed out.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  index of the requester being served; held after completion.
- mul_bgn  out  1  multiplier begin.
- mul_ibus  out  W  multiplier operand bus.
- mul_fin  in  1  multiplier done.
- mul_obus  in  W  multiplier result.

Behaviour:
- Reset values: state=IDLE, ack0=ack1=0, res=0, err=0, busy=0, gnt=0, mul_bgn=0, mul_ibus=0, opx/opy latches=0, last=1, cnt=0.
  - last=1 means requester 0 wins the first tie.
- All outputs are decoded from registered state and latches only; no combinational path from any input to any output.
- States: IDLE, LOAD_X, LOAD_Y, WAIT, DONE.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the requester != last.
  - On the granting edge: gnt<=winner, last<=winner, opx/opy<=winner's operands, state<=LOAD_X.
- LOAD_X: mul_bgn=1, mul_ibus=opx. Next edge -> LOAD_Y.
- LOAD_Y: mul_bgn=1, mul_ibus=opy. Next edge -> WAIT, cnt<=0.
- WAIT:
  - mul_bgn=0, mul_ibus=0.
  - mul_fin=1 at an edge: res<=mul_obus, err<=0, -> DONE.
  - Else if cnt==TIMEOUT-1: res<=0, err<=1, -> DONE.
  - Else cnt<=cnt+1.
- DONE: ack[gnt]=1 for exactly this cycle. Next edge -> IDLE.
- mul_fin is ignored in IDLE, LOAD_X, LOAD_Y and DONE (the multiplier's stale fin from a previous job must not complete a new one).
- Latency:
  - req sampled at edge k.
  - mul_bgn high during cycles k..k+2 (two full cycles).
  - First WAIT cycle begins at edge k+2.
  - fin sampled at edge m -> ack high between edges m and m+1.
- Minimum request-to-ack: 4 cycles (fin already high in the first WAIT cycle).
- Maximum request-to-ack: TIMEOUT+3 cycles.
- Back-to-back: a requester may keep req high after ack; it is re-sampled in IDLE, so there is one idle cycle between transactions.
  - Round-robin guarantees a waiting other requester is served next.
- Operand changes after the grant edge have no effect. A req dropped before ack is a protocol violation; the transaction still completes and acks.
- rst asserted in any state: immediate async return to reset values; mul_bgn drops without waiting for a clock. No ack is issued for the aborted job.

Test Plan:
- Single request, mock multiplier raises fin 10 cycles after bgn falls with obus=8'h45:
  - req0, x0=8'h97, y0=8'h83 -> mul_bgn high 2 cycles with ibus 8'h97 then 8'h83.
  - Then ack0 pulses once, res=8'h45, err=0, gnt=0, busy low the following cycle.
- Simultaneous req0 and req1 held high continuously from reset, x0=8'h03/y0=8'h05, x1=8'h07/y1=8'h02:
  - Serve order is 0, 1, 0, 1 (alternating gnt).
  - mul_ibus sequences are 03/05 then 07/02; each ack carries the mock's result.
- Watchdog: mock never raises fin, req1 with x1=8'h11/y1=8'h22 -> exactly TIMEOUT=16 WAIT cycles, then ack1=1, err=1, res=8'h00; next job runs normally with err=0.
- Stale fin: mul_fin held high from before the request -> fin is ignored in LOAD_X/LOAD_Y; completion occurs at the first WAIT edge (ack 4 cycles after req).
- Reset mid-operation: rst pulsed during WAIT -> asynchronously busy=0, mul_bgn=0, res=0, no ack. After release with both req high, requester 0 is served first.
- Operand stability: change x0 from 8'h97 to 8'hFF one cycle after grant -> mul_ibus still presents 8'h97 in LOAD_X.
